// File: rtl/power_spec_accum_if.sv
// Bus bundle for power_spec_accum: FFT sample input, run control and the
// spectrum readout. The master side drives control and FFT data; the slave
// side (the accumulator) drives the spectrum and status.
interface power_spec_accum_if #(
  parameter int NFFT_LOG2 = 10,
  parameter int ACC_W     = 40
);
  logic                  acc_start;
  logic [15:0]           acc_num;
  logic                  fft_dv;
  logic [NFFT_LOG2-1:0]  fft_xk_index;
  logic signed [15:0]    fft_re;
  logic signed [15:0]    fft_im;
  logic [ACC_W-1:0]      spec_data;
  logic [NFFT_LOG2-1:0]  spec_index;
  logic                  spec_valid;
  logic                  acc_busy;
  logic                  acc_done;
  logic                  ovf_err;
  logic [15:0]           frame_cnt;

  modport master (
    output acc_start, acc_num, fft_dv, fft_xk_index, fft_re, fft_im,
    input  spec_data, spec_index, spec_valid, acc_busy, acc_done, ovf_err, frame_cnt
  );

  modport slave (
    input  acc_start, acc_num, fft_dv, fft_xk_index, fft_re, fft_im,
    output spec_data, spec_index, spec_valid, acc_busy, acc_done, ovf_err, frame_cnt
  );
endinterface

// File: rtl/power_spec_accum.sv
// Power spectrum accumulator. Sums |X[k]|^2 over a programmable number of
// FFT frames into an N x ACC_W RAM (read-modify-write pipeline), then streams
// the N accumulated bins out in index order.
// Assumes NFFT_LOG2 >= 2 (a bin is revisited no sooner than 4 cycles later,
// so the RMW pipeline never reads a bin with a write still pending) and
// ACC_W >= 33 (a single 32-bit power fits without saturation).
module power_spec_accum #(
  parameter int NFFT_LOG2 = 10,
  parameter int ACC_W     = 40
) (
  input logic              clk,
  input logic              rst,
  power_spec_accum_if.slave bus
);

  localparam int N = 1 << NFFT_LOG2;
  localparam logic [NFFT_LOG2-1:0] IDX_ZERO = {NFFT_LOG2{1'b0}};
  localparam logic [NFFT_LOG2-1:0] IDX_LAST = {NFFT_LOG2{1'b1}};
  // OUTPUT lasts N read cycles plus the two-cycle read/register latency.
  localparam logic [NFFT_LOG2:0]   OUT_END  = (NFFT_LOG2+1)'(N + 1);
  localparam logic [ACC_W-1:0]     ACC_MAX  = {ACC_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  // |re|^2 + |im|^2; each square is at most 2^30, so the sum fits 32 bits.
  function automatic logic [31:0] power_f(input logic signed [15:0] re,
                                          input logic signed [15:0] im);
    logic signed [31:0] re_x;
    logic signed [31:0] im_x;
    logic [31:0]        re_sq;
    logic [31:0]        im_sq;
    re_x  = re;
    im_x  = im;
    re_sq = $unsigned(re_x * re_x);
    im_sq = $unsigned(im_x * im_x);
    return re_sq + im_sq;
  endfunction

  // Saturating add; the MSB of the result flags that saturation happened.
  function automatic logic [ACC_W:0] sat_add_f(input logic [ACC_W-1:0] acc,
                                               input logic [31:0]      pwr);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W+1-32){1'b0}}, pwr};
    if (sum[ACC_W]) begin
      return {1'b1, ACC_MAX};
    end else begin
      return sum;
    end
  endfunction

  state_t                state_r;
  state_t                state_nx_s;
  logic [15:0]           num_r;
  logic [15:0]           frame_cnt_r;
  logic                  in_frame_r;
  logic [1:0]            drain_cnt_r;
  logic [NFFT_LOG2:0]    out_cnt_r;

  // RMW pipeline: stage 1 holds the registered power alongside the RAM read,
  // stage 2 holds the sum that is written back.
  logic                  p1_valid_r;
  logic                  p1_first_r;
  logic [NFFT_LOG2-1:0]  p1_addr_r;
  logic [31:0]           p1_pow_r;
  logic                  p2_valid_r;
  logic [NFFT_LOG2-1:0]  p2_addr_r;
  logic [ACC_W-1:0]      p2_data_r;

  logic [ACC_W-1:0]      ram_r [N];
  logic [ACC_W-1:0]      rd_data_r;

  logic                  o1_valid_r;
  logic [NFFT_LOG2-1:0]  o1_idx_r;

  logic [ACC_W-1:0]      spec_data_r;
  logic [NFFT_LOG2-1:0]  spec_index_r;
  logic                  spec_valid_r;
  logic                  acc_busy_r;
  logic                  acc_done_r;
  logic                  ovf_err_r;

  logic                  accept_s;
  logic                  capture_s;
  logic                  frame_end_s;
  logic                  run_end_s;
  logic                  out_rd_s;
  logic [NFFT_LOG2-1:0]  rd_addr_s;
  logic [ACC_W:0]        sum_s;

  // A frame is only picked up from its bin 0; a partial frame seen at run
  // entry has in_frame_r low and a non-zero index, so it is skipped.
  assign accept_s    = (state_r == ST_IDLE) && bus.acc_start;
  assign capture_s   = (state_r == ST_ACCUM) && bus.fft_dv &&
                       ((bus.fft_xk_index == IDX_ZERO) || in_frame_r);
  assign frame_end_s = capture_s && (bus.fft_xk_index == IDX_LAST);
  assign run_end_s   = frame_end_s &&
                       (({1'b0, frame_cnt_r} + 17'd1) == {1'b0, num_r});
  assign out_rd_s    = (state_r == ST_OUTPUT) && !out_cnt_r[NFFT_LOG2];

  // RAM read address: readout counter in OUTPUT, FFT bin otherwise.
  always_comb begin
    rd_addr_s = bus.fft_xk_index;
    if (out_rd_s) begin
      rd_addr_s = out_cnt_r[NFFT_LOG2-1:0];
    end else begin
      rd_addr_s = bus.fft_xk_index;
    end
  end

  // Write-back value: first frame of a run overwrites, later frames add.
  always_comb begin
    sum_s = {(ACC_W+1){1'b0}};
    if (p1_first_r) begin
      sum_s = {1'b0, {(ACC_W-32){1'b0}}, p1_pow_r};
    end else begin
      sum_s = sat_add_f(rd_data_r, p1_pow_r);
    end
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_ACCUM;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (run_end_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 2'd2) begin
          state_nx_s = ST_OUTPUT;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_OUTPUT: begin
        if (out_cnt_r == OUT_END) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OUTPUT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Run control: latched frame count, frame tracking, phase counters, status.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_r       <= 16'd1;
      frame_cnt_r <= 16'd0;
      in_frame_r  <= 1'b0;
      drain_cnt_r <= 2'd0;
      out_cnt_r   <= {(NFFT_LOG2+1){1'b0}};
      acc_busy_r  <= 1'b0;
      acc_done_r  <= 1'b0;
      ovf_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        num_r       <= (bus.acc_num == 16'd0) ? 16'd1 : bus.acc_num;
        frame_cnt_r <= 16'd0;
      end else if (frame_end_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end

      if (state_r != ST_ACCUM) begin
        in_frame_r <= 1'b0;
      end else if (frame_end_s) begin
        in_frame_r <= 1'b0;
      end else if (capture_s) begin
        in_frame_r <= 1'b1;
      end

      drain_cnt_r <= (state_r == ST_DRAIN) ? (drain_cnt_r + 2'd1) : 2'd0;
      out_cnt_r   <= (state_r == ST_OUTPUT) ? (out_cnt_r + {{NFFT_LOG2{1'b0}}, 1'b1})
                                            : {(NFFT_LOG2+1){1'b0}};
      acc_busy_r  <= (state_nx_s != ST_IDLE);
      acc_done_r  <= (state_r == ST_OUTPUT) && (state_nx_s == ST_IDLE);

      if (accept_s) begin
        ovf_err_r <= 1'b0;
      end else if (p1_valid_r && sum_s[ACC_W]) begin
        ovf_err_r <= 1'b1;
      end
    end
  end

  // Read-modify-write pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_r <= 1'b0;
      p1_first_r <= 1'b0;
      p1_addr_r  <= {NFFT_LOG2{1'b0}};
      p1_pow_r   <= 32'd0;
      p2_valid_r <= 1'b0;
      p2_addr_r  <= {NFFT_LOG2{1'b0}};
      p2_data_r  <= {ACC_W{1'b0}};
    end else begin
      p1_valid_r <= capture_s;
      p1_first_r <= (frame_cnt_r == 16'd0);
      p1_addr_r  <= bus.fft_xk_index;
      p1_pow_r   <= power_f(bus.fft_re, bus.fft_im);
      p2_valid_r <= p1_valid_r;
      p2_addr_r  <= p1_addr_r;
      p2_data_r  <= sum_s[ACC_W-1:0];
    end
  end

  // Accumulator RAM: one write port, one synchronous read port; contents
  // are not reset because the first frame of every run overwrites them.
  always_ff @(posedge clk) begin
    if (p2_valid_r) begin
      ram_r[p2_addr_r] <= p2_data_r;
    end
    rd_data_r <= ram_r[rd_addr_s];
  end

  // Spectrum readout: index follows the RAM read by one cycle, then both
  // are registered onto the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      o1_valid_r   <= 1'b0;
      o1_idx_r     <= {NFFT_LOG2{1'b0}};
      spec_valid_r <= 1'b0;
      spec_index_r <= {NFFT_LOG2{1'b0}};
      spec_data_r  <= {ACC_W{1'b0}};
    end else begin
      o1_valid_r   <= out_rd_s;
      o1_idx_r     <= out_cnt_r[NFFT_LOG2-1:0];
      spec_valid_r <= o1_valid_r;
      if (o1_valid_r) begin
        spec_index_r <= o1_idx_r;
        spec_data_r  <= rd_data_r;
      end
    end
  end

  assign bus.spec_data  = spec_data_r;
  assign bus.spec_index = spec_index_r;
  assign bus.spec_valid = spec_valid_r;
  assign bus.acc_busy   = acc_busy_r;
  assign bus.acc_done   = acc_done_r;
  assign bus.ovf_err    = ovf_err_r;
  assign bus.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_power_spec_accum.sv
// Directed bench for power_spec_accum with N = 8, ACC_W = 40.
module tb_power_spec_accum;

  localparam int NL = 3;
  localparam int N  = 8;
  localparam int AW = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic [AW-1:0] exp_mem [N];

  always #5 clk = ~clk;

  power_spec_accum_if #(.NFFT_LOG2(NL), .ACC_W(AW)) bus ();

  power_spec_accum #(.NFFT_LOG2(NL), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Count end-of-run pulses.
  always @(posedge clk) begin
    if (bus.acc_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.acc_start    = 1'b0;
    bus.fft_dv       = 1'b0;
    bus.fft_xk_index = 3'd0;
    bus.fft_re       = 16'sd0;
    bus.fft_im       = 16'sd0;
  endtask

  task automatic start_run(input logic [15:0] num);
    bus.acc_start = 1'b1;
    bus.acc_num   = num;
    step();
    bus.acc_start = 1'b0;
  endtask

  // One full frame; ramp!=0 gives re=k on bin k. stall_at inserts two dv-low
  // cycles before that bin (-1: no stall).
  task automatic send_frame(input int ramp, input logic signed [15:0] re,
                            input logic signed [15:0] im, input int stall_at);
    for (int k = 0; k < N; k++) begin
      if (k == stall_at) begin
        bus.fft_dv = 1'b0;
        step();
        step();
      end
      bus.fft_dv       = 1'b1;
      bus.fft_xk_index = 3'(k);
      bus.fft_re       = (ramp != 0) ? 16'(k) : re;
      bus.fft_im       = im;
      step();
    end
  endtask

  // Wait for the readout and compare all N words against exp_mem.
  task automatic collect(input string tag, input int exp_lat);
    int lat = 0;
    while (bus.spec_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    for (int k = 0; k < N; k++) begin
      check({tag, "_valid"}, 64'(bus.spec_valid), 64'(1));
      check({tag, "_index"}, 64'(bus.spec_index), 64'(k));
      check({tag, "_data"},  64'(bus.spec_data),  64'(exp_mem[k]));
      step();
    end
    check({tag, "_done_pulse"}, 64'(bus.acc_done),   64'(1));
    check({tag, "_busy_end"},   64'(bus.acc_busy),   64'(0));
    check({tag, "_valid_end"},  64'(bus.spec_valid), 64'(0));
  endtask

  initial begin
    int g;
    idle_in();
    bus.acc_num = 16'd0;
    rst = 1'b1;
    step();
    step();
    check("rst_spec_data",  64'(bus.spec_data),  64'(0));
    check("rst_spec_index", 64'(bus.spec_index), 64'(0));
    check("rst_spec_valid", 64'(bus.spec_valid), 64'(0));
    check("rst_busy",       64'(bus.acc_busy),   64'(0));
    check("rst_done",       64'(bus.acc_done),   64'(0));
    check("rst_ovf",        64'(bus.ovf_err),    64'(0));
    check("rst_frame_cnt",  64'(bus.frame_cnt),  64'(0));
    rst = 1'b0;
    step();

    // Two back-to-back frames of 3+4j: 2 * 25 per bin.
    start_run(16'd2);
    check("t1_busy", 64'(bus.acc_busy), 64'(1));
    send_frame(0, 16'sd3, 16'sd4, -1);
    send_frame(0, 16'sd3, 16'sd4, -1);
    idle_in();
    check("t1_frame_cnt", 64'(bus.frame_cnt), 64'(2));
    for (int k = 0; k < N; k++) exp_mem[k] = 40'd50;
    collect("t1", 5);
    step();
    check("t1_done_cnt", 64'(done_cnt), 64'(1));
    check("t1_done_once", 64'(bus.acc_done), 64'(0));
    check("t1_frame_cnt_hold", 64'(bus.frame_cnt), 64'(2));

    // Start lands at bin 4 of a frame of 7+0j: that partial frame is skipped,
    // the next frame 1+2j (power 5) counts, later samples are ignored.
    for (int k = 0; k < N; k++) begin
      bus.fft_dv       = 1'b1;
      bus.fft_xk_index = 3'(k);
      bus.fft_re       = 16'sd7;
      bus.fft_im       = 16'sd0;
      bus.acc_start    = (k == 4);
      bus.acc_num      = 16'd1;
      step();
    end
    bus.acc_start = 1'b0;
    send_frame(0, 16'sd1, 16'sd2, -1);
    for (int k = 0; k < 3; k++) begin
      bus.fft_xk_index = 3'(k);
      bus.fft_re       = 16'sd9;
      step();
    end
    bus.fft_xk_index = 3'd0;
    bus.fft_re       = 16'sd100;
    for (int k = 0; k < N; k++) exp_mem[k] = 40'd5;
    collect("t2", -1);
    idle_in();
    step();
    check("t2_done_cnt",  64'(done_cnt),      64'(2));
    check("t2_frame_cnt", 64'(bus.frame_cnt), 64'(1));

    // Ramp re=k, three frames; an acc_start mid-run must not change the count.
    start_run(16'd3);
    check("t3_frame_cnt_clr", 64'(bus.frame_cnt), 64'(0));
    send_frame(1, 16'sd0, 16'sd0, -1);
    idle_in();
    check("t3_frame_cnt_1", 64'(bus.frame_cnt), 64'(1));
    bus.acc_start = 1'b1;
    bus.acc_num   = 16'd2;
    step();
    bus.acc_start = 1'b0;
    check("t3_busy", 64'(bus.acc_busy), 64'(1));
    send_frame(1, 16'sd0, 16'sd0, 3);
    send_frame(1, 16'sd0, 16'sd0, -1);
    idle_in();
    check("t3_frame_cnt_3", 64'(bus.frame_cnt), 64'(3));
    for (int k = 0; k < N; k++) exp_mem[k] = 40'(3 * k * k);
    collect("t3", 5);
    step();
    check("t3_done_cnt", 64'(done_cnt), 64'(3));

    // acc_num=0 acts as one frame; no carry-over from the previous run.
    start_run(16'd0);
    send_frame(1, 16'sd0, 16'sd0, -1);
    idle_in();
    check("t4_frame_cnt", 64'(bus.frame_cnt), 64'(1));
    for (int k = 0; k < N; k++) exp_mem[k] = 40'(k * k);
    collect("t4", 5);
    step();
    check("t4_done_cnt", 64'(done_cnt), 64'(4));

    // Full-scale input for 1000 frames saturates every bin.
    start_run(16'd1000);
    for (int f = 0; f < 1000; f++) send_frame(0, -16'sd32768, -16'sd32768, -1);
    idle_in();
    check("t5_frame_cnt", 64'(bus.frame_cnt), 64'(1000));
    check("t5_ovf", 64'(bus.ovf_err), 64'(1));
    for (int k = 0; k < N; k++) exp_mem[k] = {AW{1'b1}};
    collect("t5", 5);
    step();
    check("t5_done_cnt", 64'(done_cnt), 64'(5));
    check("t5_ovf_sticky", 64'(bus.ovf_err), 64'(1));

    // Reset in the middle of the readout (word 3).
    start_run(16'd1);
    check("t6_ovf_clr", 64'(bus.ovf_err), 64'(0));
    send_frame(0, 16'sd2, 16'sd0, -1);
    idle_in();
    g = 0;
    while (!(bus.spec_valid === 1'b1 && bus.spec_index === 3'd3) && g < 100) begin
      step();
      g++;
    end
    check("t6_word3_index", 64'(bus.spec_index), 64'(3));
    check("t6_word3_data",  64'(bus.spec_data),  64'(4));
    rst = 1'b1;
    step();
    check("t6_rst_valid", 64'(bus.spec_valid), 64'(0));
    check("t6_rst_busy",  64'(bus.acc_busy),   64'(0));
    check("t6_rst_done",  64'(bus.acc_done),   64'(0));
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("t6_no_done",     64'(done_cnt),       64'(5));
    check("t6_idle_valid",  64'(bus.spec_valid), 64'(0));
    check("t6_idle_busy",   64'(bus.acc_busy),   64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/power_spec_accum.md
POWER_SPEC_ACCUM -- requirements
Module: power_spec_accum

Interface
REQ-001 SHALL have parameter NFFT_LOG2, default 10, log2 of FFT length N (N = 2^NFFT_LOG2).
REQ-002 SHALL have parameter ACC_W, default 40, accumulator and output word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port acc_start  input  1  one-cycle pulse that begins an accumulation run.
REQ-006 SHALL have port acc_num  input  16  frames to accumulate, latched on an accepted acc_start.
REQ-007 SHALL have port fft_dv  input  1  FFT output data valid.
REQ-008 SHALL have port fft_xk_index  input  NFFT_LOG2  FFT output bin index.
REQ-009 SHALL have ports fft_re and fft_im  input  16 each  FFT output, two's complement.
REQ-010 SHALL have port spec_data  output  ACC_W  accumulated power of one bin, unsigned.
REQ-011 SHALL have port spec_index  output  NFFT_LOG2  bin index of spec_data.
REQ-012 SHALL have port spec_valid  output  1  spec_data/spec_index valid.
REQ-013 SHALL have ports acc_busy, acc_done, ovf_err  output  1 each  run active; one-cycle end-of-run pulse; saturation occurred in the run.
REQ-014 SHALL have port frame_cnt  output  16  frames accumulated in the current run.

Function
REQ-015 SHALL implement states IDLE, ACCUM, DRAIN, OUTPUT.
REQ-016 IDLE->ACCUM on acc_start; latch acc_num (0 treated as 1); clear frame_cnt and ovf_err.
REQ-017 acc_start outside IDLE SHALL be ignored.
REQ-018 In ACCUM, a frame SHALL be captured only if it begins with fft_dv=1 and fft_xk_index=0 while in ACCUM; samples of a partial frame already in progress at entry SHALL be ignored.
REQ-019 Per captured sample: power = fft_re^2 + fft_im^2, computed as 32-bit unsigned without loss (max 2^31).
REQ-020 Accumulation SHALL be a read-modify-write on an N x ACC_W RAM addressed by fft_xk_index: read at sample cycle t, squares registered at t+1, sum written at t+2.
REQ-021 For the first captured frame of a run the RAM SHALL be written with power alone (no read-add), so no clear pass is needed.
REQ-022 Sum exceeding 2^ACC_W-1 SHALL saturate to all-ones and set ovf_err (sticky until next accepted acc_start).
REQ-023 frame_cnt SHALL increment on the cycle after a captured sample with fft_xk_index=N-1.
REQ-024 When frame_cnt reaches the latched count, ACCUM->DRAIN; further fft_dv SHALL be ignored until the next run.
REQ-025 DRAIN SHALL last 3 cycles so the last write completes, then ->OUTPUT.
REQ-026 OUTPUT SHALL read bins 0..N-1 in order; spec_valid high for N consecutive cycles starting 2 cycles after OUTPUT entry, spec_index = 0..N-1 matching spec_data.
REQ-027 fft_dv in OUTPUT SHALL be ignored.
REQ-028 acc_done SHALL pulse one cycle on the cycle after the last spec_valid; state SHALL return to IDLE on that same cycle.
REQ-029 acc_busy SHALL be 1 in ACCUM, DRAIN, OUTPUT; 0 in IDLE.
REQ-030 Back-to-back frames (index N-1 followed directly by 0) SHALL be accumulated with no lost sample.
REQ-031 fft_dv low mid-frame SHALL stall capture without aborting the frame; the index sequence continues when fft_dv returns.

Reset
REQ-032 rst SHALL force IDLE from any state, including mid-frame and mid-OUTPUT, on the next rising edge.
REQ-033 On reset spec_data=0, spec_index=0, spec_valid=0, acc_busy=0, acc_done=0, ovf_err=0, frame_cnt=0; RAM contents need not be cleared.

Verification (NFFT_LOG2=3, ACC_W=40 unless noted)
REQ-034 acc_num=2, two frames re=3, im=4 all bins -> 8 words spec_data=50, spec_index 0..7, acc_done once, frame_cnt=2.
REQ-035 acc_start while a frame is at index 4 -> partial frame ignored; next full frame counted; acc_num=1 output equals that frame's power.
REQ-036 re=im=-32768, acc_num=1000, ACC_W=40 -> spec_data=2^40-1, ovf_err=1.
REQ-037 Frames back-to-back with bin k carrying re=k, im=0, acc_num=3 -> spec_data[k]=3*k^2; then second run acc_num=1 -> k^2 (no carry-over).
REQ-038 rst asserted during OUTPUT word 3 -> spec_valid=0, acc_busy=0 next cycle; no acc_done.
REQ-039 acc_num=0 -> behaves as 1; acc_start during ACCUM -> ignored, latched count unchanged.
